// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key arbiter: key count, key-index
//                width, debounce counter width and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int KEY_NUM   = 4;
    localparam int KEY_IDX_W = 2;
    localparam int CNT_W     = 20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_t;

    // Index one past idx, wrapping from the last key back to key 0.
    function automatic logic [KEY_IDX_W-1:0] next_idx(input logic [KEY_IDX_W-1:0] idx);
        next_idx = (idx == KEY_IDX_W'(KEY_NUM - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_arbiter_if
//  Description : Key-side bundle: raw active-low keys in, debounced press
//                pulse, owning key index and busy status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_arbiter_if;
    import key_pkg::*;

    logic [KEY_NUM-1:0]   key_in;
    logic                 key_flag;
    logic [KEY_IDX_W-1:0] key_id;
    logic                 busy;

    // Driver side of the raw keys, consumer of the press events.
    modport master (
        output key_in,
        input  key_flag,
        input  key_id,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  key_in,
        output key_flag,
        output key_id,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/key_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : key_rr_sel
//  Description : Combinational rotating-priority pick. Scans req starting at
//                ptr and wrapping; the first asserted request wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_rr_sel
    import key_pkg::*;
(
    input  wire logic [KEY_NUM-1:0]   req,
    input  wire logic [KEY_IDX_W-1:0] ptr,
    output logic                      gnt_valid,
    output logic [KEY_IDX_W-1:0]      gnt_idx
);

    // Walk offsets from farthest to nearest so the offset closest to ptr
    // is the last to write and therefore wins.
    always_comb begin
        logic [KEY_IDX_W-1:0] w_idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            w_idx = ptr + KEY_IDX_W'(i);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : key_arbiter
//  Description : Four raw keys share a single debounce counter. A round-robin
//                scan picks one pressed key, debounces its press, emits one
//                pulse with its index, then debounces its release before the
//                counter is handed to the next key.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_arbiter #(
    parameter logic [19:0] CNT_MAX_20MS = 20'd24,
    parameter int          KEY_NUM      = 4
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    key_arbiter_if.slave      bus
);

    key_pkg::key_state_t                r_state;
    logic [key_pkg::CNT_W-1:0]          r_cnt;
    logic [key_pkg::KEY_IDX_W-1:0]      r_ptr;
    logic [key_pkg::KEY_IDX_W-1:0]      r_sel;
    logic                               r_key_flag;
    logic [key_pkg::KEY_IDX_W-1:0]      r_key_id;
    logic                               r_busy;

    logic                               w_gnt_valid;
    logic [key_pkg::KEY_IDX_W-1:0]      w_gnt_idx;
    logic                               w_sel_low;
    logic                               w_cnt_done;
    logic [key_pkg::KEY_IDX_W-1:0]      w_ptr_next;

    key_rr_sel u_rr_sel (
        .req       (~bus.key_in),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_sel_low  = ~bus.key_in[r_sel];
    assign w_cnt_done = (r_cnt == (CNT_MAX_20MS - 20'd1));
    // Priority moves one past the key that just gave up the counter.
    assign w_ptr_next = (r_sel == key_pkg::KEY_IDX_W'(KEY_NUM - 1)) ? '0 : r_sel + 1'b1;

    // Arbitration / debounce FSM with registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= key_pkg::ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_key_flag <= 1'b0;
            r_key_id   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_key_flag <= 1'b0;
            case (r_state)
                key_pkg::ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_sel   <= w_gnt_idx;
                        r_cnt   <= '0;
                        r_state <= key_pkg::ST_DEBOUNCE;
                        r_busy  <= 1'b1;
                    end
                end
                key_pkg::ST_DEBOUNCE: begin
                    if (w_sel_low) begin
                        if (w_cnt_done) begin
                            r_state    <= key_pkg::ST_PRESSED;
                            r_cnt      <= '0;
                            r_key_flag <= 1'b1;
                            r_key_id   <= r_sel;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        // Glitch: abandon without a pulse and pass priority on.
                        r_state <= key_pkg::ST_IDLE;
                        r_cnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                    end
                end
                key_pkg::ST_PRESSED: begin
                    if (!w_sel_low) begin
                        r_state <= key_pkg::ST_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                key_pkg::ST_RELEASE: begin
                    if (w_sel_low) begin
                        // Release bounce: back to held, no new pulse.
                        r_state <= key_pkg::ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_done) begin
                        r_state <= key_pkg::ST_IDLE;
                        r_cnt   <= '0;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= key_pkg::ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_flag = r_key_flag;
    assign bus.key_id   = r_key_id;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_arbiter
//  Description : Directed self-checking bench for key_arbiter with a debounce
//                length of 24 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    int   pulses  = 0;
    logic prev_flag = 1'b0;

    key_arbiter_if bus ();

    key_arbiter #(
        .CNT_MAX_20MS (20'd24),
        .KEY_NUM      (4)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // 10-unit clock period.
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Count pulses mid-cycle and flag any back-to-back pulse.
    always @(negedge sys_clk) begin
        if (bus.key_flag === 1'b1) begin
            pulses++;
            checks++;
            assert (prev_flag === 1'b0) else begin
                errors++;
                $error("FAIL consecutive_flag observed=1 expected=0");
            end
        end
        prev_flag = bus.key_flag;
    end

    initial begin
        bus.key_in = 4'hF;
        #2;
        // Reset state
        check("rst_flag", 32'(bus.key_flag), 0);
        check("rst_id",   32'(bus.key_id),   0);
        check("rst_busy", 32'(bus.busy),     0);
        step(2);
        sys_rst = 1'b0;
        step(2);
        check("idle_busy", 32'(bus.busy), 0);

        // Key 2 held 40 cycles: pulse right after edge 24, then release debounce
        bus.key_in = 4'b1011;
        step(1);
        check("s1_busy_up", 32'(bus.busy), 1);
        step(23);
        check("s1_flag_early", 32'(bus.key_flag), 0);
        step(1);
        check("s1_flag", 32'(bus.key_flag), 1);
        check("s1_id",   32'(bus.key_id),   2);
        step(1);
        check("s1_flag_off", 32'(bus.key_flag), 0);
        check("s1_id_held",  32'(bus.key_id),   2);
        step(14);
        bus.key_in = 4'hF;
        step(24);
        check("s1_busy_hold", 32'(bus.busy), 1);
        step(1);
        check("s1_busy_drop", 32'(bus.busy), 0);
        check("s1_pulses", 32'(pulses), 1);

        // Key 0: 10-cycle glitch, then a real 30-cycle press
        bus.key_in = 4'b1110;
        step(10);
        bus.key_in = 4'hF;
        step(2);
        check("s2_glitch_busy",   32'(bus.busy), 0);
        check("s2_glitch_pulses", 32'(pulses),   1);
        bus.key_in = 4'b1110;
        step(24);
        check("s2_flag_early", 32'(bus.key_flag), 0);
        step(1);
        check("s2_flag", 32'(bus.key_flag), 1);
        check("s2_id",   32'(bus.key_id),   0);
        step(5);
        bus.key_in = 4'hF;
        step(26);
        check("s2_busy_drop", 32'(bus.busy), 0);
        check("s2_pulses", 32'(pulses), 2);

        // Keys 1 and 3 from reset: key 1 first, key 3 after key 1 releases
        sys_rst = 1'b1;
        #1;
        check("s3_rst_busy", 32'(bus.busy), 0);
        step(1);
        sys_rst = 1'b0;
        bus.key_in = 4'b0101;
        step(25);
        check("s3_flag1", 32'(bus.key_flag), 1);
        check("s3_id1",   32'(bus.key_id),   1);
        step(3);
        bus.key_in = 4'b0111;
        step(25);
        check("s3_gap_busy", 32'(bus.busy), 0);
        step(1);
        check("s3_key3_busy", 32'(bus.busy), 1);
        step(23);
        check("s3_flag3_early", 32'(bus.key_flag), 0);
        step(1);
        check("s3_flag3", 32'(bus.key_flag), 1);
        check("s3_id3",   32'(bus.key_id),   3);
        bus.key_in = 4'hF;
        step(26);
        check("s3_busy_drop", 32'(bus.busy), 0);
        check("s3_pulses", 32'(pulses), 4);

        // Key 2 with a 3-cycle bounce during release
        bus.key_in = 4'b1011;
        step(25);
        check("s4_flag", 32'(bus.key_flag), 1);
        check("s4_id",   32'(bus.key_id),   2);
        step(2);
        bus.key_in = 4'hF;
        step(5);
        bus.key_in = 4'b1011;
        step(3);
        check("s4_bounce_busy", 32'(bus.busy), 1);
        bus.key_in = 4'hF;
        step(24);
        check("s4_restart_busy", 32'(bus.busy), 1);
        step(1);
        check("s4_busy_drop", 32'(bus.busy), 0);
        check("s4_pulses", 32'(pulses), 5);

        // Reset at DEBOUNCE cnt=15 with key 1 held
        bus.key_in = 4'b1101;
        step(16);
        check("s5_busy_pre", 32'(bus.busy), 1);
        sys_rst = 1'b1;
        #1;
        check("s5_rst_flag", 32'(bus.key_flag), 0);
        check("s5_rst_id",   32'(bus.key_id),   0);
        check("s5_rst_busy", 32'(bus.busy),     0);
        step(2);
        sys_rst = 1'b0;
        check("s5_abort_pulses", 32'(pulses), 5);
        step(24);
        check("s5_flag_early", 32'(bus.key_flag), 0);
        step(1);
        check("s5_flag", 32'(bus.key_flag), 1);
        check("s5_id",   32'(bus.key_id),   1);
        bus.key_in = 4'hF;
        step(26);
        check("s5_busy_drop", 32'(bus.busy), 0);

        // All four keys pressed repeatedly: ids rotate 0,1,2,3,0
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.key_in = 4'b0000;
            step(25);
            check("s6_flag", 32'(bus.key_flag), 1);
            check("s6_id",   32'(bus.key_id),   32'(i % 4));
            bus.key_in = 4'hF;
            step(26);
            check("s6_busy_drop", 32'(bus.busy), 0);
        end
        check("s6_pulses", 32'(pulses), 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_arbiter.md
KEY_ARBITER -- requirements
Module: key_arbiter

Interface
REQ-001 Parameter CNT_MAX_20MS, default 20'd24, SHALL set the number of stable cycles for press and release debounce (20 ms at board clock; 24 in simulation).
REQ-002 Parameter KEY_NUM, default 4, SHALL set the number of raw keys; only the value 4 is supported.
REQ-003 sys_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 key_in  input  4  SHALL carry raw key levels, active-low (0 = pressed), already synchronised to sys_clk.
REQ-006 key_flag  output  1  SHALL be a one-cycle pulse marking one debounced press.
REQ-007 key_id  output  2  SHALL give the index of the key owning the pulse; valid while key_flag=1, held otherwise.
REQ-008 busy  output  1  SHALL be 1 whenever the shared debounce counter is owned by a key (state != IDLE).

Function
REQ-009 The block SHALL share one 20-bit debounce counter cnt among the four keys under a 4-state FSM: IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-010 IDLE: sel SHALL be the first key with key_in=0, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4); if one is found, next state SHALL be DEBOUNCE with cnt=0, otherwise IDLE.
REQ-011 DEBOUNCE, key_in[sel]=0, cnt!=CNT_MAX_20MS-1: cnt SHALL increment by 1.
REQ-012 DEBOUNCE, key_in[sel]=0, cnt==CNT_MAX_20MS-1: next state SHALL be PRESSED; key_flag=1 and key_id=sel on the following cycle.
REQ-013 DEBOUNCE, key_in[sel]=1: next state SHALL be IDLE with no pulse, ptr=sel+1 mod 4.
REQ-014 Press latency: with key_in[sel] held low from the IDLE sampling edge (edge 0), key_flag SHALL be high in the cycle after edge CNT_MAX_20MS.
REQ-015 PRESSED: while key_in[sel]=0 the state SHALL hold; on key_in[sel]=1, next state SHALL be RELEASE with cnt=0.
REQ-016 RELEASE: key_in[sel]=1 SHALL increment cnt; at cnt==CNT_MAX_20MS-1, next state SHALL be IDLE with ptr=sel+1 mod 4.
REQ-017 RELEASE: key_in[sel]=0 SHALL return the state to PRESSED with cnt=0 and no new pulse (release bounce).
REQ-018 Keys other than sel SHALL be ignored outside IDLE; a key still low when IDLE is re-entered SHALL be eligible in the next scan.
REQ-019 key_flag SHALL never be high on two consecutive cycles; exactly one pulse per PRESSED entry.
REQ-020 cnt SHALL never exceed CNT_MAX_20MS-1; no wrap-around.
REQ-021 ptr rotation SHALL wrap 3->0.

Reset
REQ-022 On sys_rst=1, asynchronously: state=IDLE, cnt=0, ptr=0, sel=0, key_flag=0, key_id=0, busy=0.
REQ-023 Reset mid-operation SHALL abort any debounce without a pulse; after release, a key held low SHALL restart a full debounce.

Structure
REQ-024 Package key_pkg SHALL hold the FSM state encoding, KEY_NUM and the key-index width.
REQ-025 The rotating-priority pick SHALL be the sub-module key_rr_sel (combinational; inputs: req[3:0] = ~key_in, ptr[1:0]; outputs: gnt_valid, gnt_idx[1:0]).

Verification (CNT_MAX_20MS=24)
REQ-026 Key 2 low for 40 cycles, then high -> single key_flag pulse, key_id=2, in the cycle after edge 24; busy drops 24 cycles after release.
REQ-027 Key 0 low for 10 cycles, high, then low for 30 cycles -> no pulse for the first glitch; one pulse for the second press with key_id=0.
REQ-028 Keys 1 and 3 low simultaneously from reset (ptr=0) -> pulse key_id=1; after key 1 releases and its release debounce completes, a pulse with key_id=3 while key 3 is still held.
REQ-029 In RELEASE, key 2 bounces low for 3 cycles -> no second pulse; RELEASE restarts and busy stays 1.
REQ-030 sys_rst asserted at DEBOUNCE cnt=15 -> outputs 0 immediately; the held key pulses 24 cycles after reset deassertion.
REQ-031 All four keys pressed and released repeatedly -> pulses rotate key_id 0,1,2,3,0 (round-robin fairness).
